// File: rtl/execute_stage.sv
// RV32I execute stage: forwarded operand select, ALU, branch/jump resolution and the
// registered execute-to-memory slot with valid/ready handshake, redirect pulse and sticky halt.
module execute_stage #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,

  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic            in_halt,
  input  logic [3:0]      in_alu_op,
  input  logic [4:0]      in_rd,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic            in_dread,
  input  logic [1:0]      in_dwrite,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_alu_src1,
  input  logic            in_alu_src2,
  input  logic [1:0]      in_reg_wr_src,
  input  logic            in_branch_pol,
  input  logic [1:0]      in_pc_ctrl,
  input  logic [XLEN-1:0] in_rdat1,
  input  logic [XLEN-1:0] in_rdat2,

  input  logic            fwd_mem_en,
  input  logic [4:0]      fwd_mem_rd,
  input  logic [XLEN-1:0] fwd_mem_data,
  input  logic            fwd_wb_en,
  input  logic [4:0]      fwd_wb_rd,
  input  logic [XLEN-1:0] fwd_wb_data,

  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_alu,
  output logic [XLEN-1:0] out_sdata,
  output logic [XLEN-1:0] out_pc4,
  output logic [4:0]      out_rd,
  output logic            out_dread,
  output logic [1:0]      out_dwrite,
  output logic [1:0]      out_reg_wr_src,
  output logic            out_halt,

  output logic            redirect,
  output logic [XLEN-1:0] redirect_target,
  output logic            halted
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    PC_INC    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JAL    = 2'd2,
    PC_JALR   = 2'd3
  } pc_ctrl_t;

  alu_op_t         alu_op;
  pc_ctrl_t        pc_ctrl;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_res;
  logic            zero;
  logic            taken;
  logic [XLEN-1:0] target;
  logic            accept;

  assign alu_op   = alu_op_t'(in_alu_op);
  assign pc_ctrl  = pc_ctrl_t'(in_pc_ctrl);
  assign in_ready = !halted && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready && !flush;

  // x0 is hardwired; the younger MEM result shadows an older WB result for the same register.
  always_comb begin
    rs1_val = in_rdat1;
    if (in_rs1 == 5'd0)
      rs1_val = '0;
    else if (fwd_mem_en && (fwd_mem_rd == in_rs1))
      rs1_val = fwd_mem_data;
    else if (fwd_wb_en && (fwd_wb_rd == in_rs1))
      rs1_val = fwd_wb_data;
  end

  always_comb begin
    rs2_val = in_rdat2;
    if (in_rs2 == 5'd0)
      rs2_val = '0;
    else if (fwd_mem_en && (fwd_mem_rd == in_rs2))
      rs2_val = fwd_mem_data;
    else if (fwd_wb_en && (fwd_wb_rd == in_rs2))
      rs2_val = fwd_wb_data;
  end

  assign op_a  = in_alu_src1 ? in_pc : rs1_val;
  assign op_b  = in_alu_src2 ? in_imm : rs2_val;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_SLL:  alu_res = op_a << shamt;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SRL:  alu_res = op_a >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
      ALU_OR:   alu_res = op_a | op_b;
      ALU_AND:  alu_res = op_a & op_b;
      default:  alu_res = '0;
    endcase
  end

  assign zero = (alu_res == '0);

  // Branches compare through the ALU zero flag; polarity selects BEQ-style or BNE-style.
  always_comb begin
    taken  = 1'b0;
    target = in_pc + in_imm;
    case (pc_ctrl)
      PC_BRANCH: taken = zero ^ in_branch_pol;
      PC_JAL:    taken = 1'b1;
      PC_JALR: begin
        taken  = 1'b1;
        target = (rs1_val + in_imm) & ~{{(XLEN-1){1'b0}}, 1'b1};
      end
      default:   taken = 1'b0;
    endcase
  end

  // The slot payload only changes on accept, so a stalled or flushed slot keeps its contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid       <= 1'b0;
      out_pc          <= RESET_PC;
      out_alu         <= '0;
      out_sdata       <= '0;
      out_pc4         <= '0;
      out_rd          <= '0;
      out_dread       <= 1'b0;
      out_dwrite      <= '0;
      out_reg_wr_src  <= '0;
      out_halt        <= 1'b0;
      redirect        <= 1'b0;
      redirect_target <= RESET_PC;
      halted          <= 1'b0;
    end else if (accept) begin
      out_valid       <= 1'b1;
      out_pc          <= in_pc;
      out_alu         <= alu_res;
      out_sdata       <= rs2_val;
      out_pc4         <= in_pc + XLEN'(4);
      out_rd          <= in_rd;
      out_dread       <= in_dread;
      out_dwrite      <= in_dwrite;
      out_reg_wr_src  <= in_reg_wr_src;
      out_halt        <= in_halt;
      redirect        <= taken;
      redirect_target <= target;
      if (in_halt)
        halted <= 1'b1;
    end else begin
      out_valid <= out_valid && !flush && !out_ready;
      redirect  <= 1'b0;
    end
  end

endmodule
